// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and BCD compare constants for the mm:ss timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } timer_state_e;

    localparam logic [7:0]  BCD_ZERO     = 8'h00;
    localparam logic [15:0] CNT_ZERO     = 16'h0000;
    localparam logic [15:0] CNT_ONE_SEC  = 16'h0001;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running modulo-TICK_DIV counter with a one-cycle tick at its last count
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int             W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over enable so a pending abort never lets the phase advance.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - run/pause/alarm sequencer driving load and decrement strobes of the BCD counters
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [7:0] cfg_min,
    input  logic [7:0] cfg_sec,
    input  logic [7:0] cnt_min,
    input  logic [7:0] cnt_sec,
    output logic       load,
    output logic       sec_dec,
    output logic       min_dec,
    output logic       alarm,
    output logic       running,
    output logic [1:0] state
);

    localparam int            AW         = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    timer_state_e  state_q, state_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          tick;
    logic          presc_en;
    logic          presc_clr;
    logic          cnt_zero;
    logic          cnt_one;

    assign cnt_zero = ({cnt_min, cnt_sec} == CNT_ZERO);
    assign cnt_one  = ({cnt_min, cnt_sec} == CNT_ONE_SEC);

    // One prescaler serves both the countdown and the alarm duration.
    assign presc_en  = (state_q == RUN) || (state_q == ALARM);
    assign presc_clr = (state_d == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable_i (presc_en),
        .clear_i  (presc_clr),
        .tick_o   (tick)
    );

    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        load        = 1'b0;
        sec_dec     = 1'b0;
        min_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = 1'b1;
                if (start && ({cfg_min, cfg_sec} != CNT_ZERO)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick && !cnt_zero) begin
                    sec_dec = 1'b1;
                    min_dec = (cnt_sec == BCD_ZERO);
                end
                // A tick landing with pause still decrements; pause then wins over the alarm move.
                if (pause) begin
                    state_d = PAUSE;
                end else if (tick && (cnt_zero || cnt_one)) begin
                    state_d = ALARM;
                end
            end
            PAUSE: begin
                if (start && !pause) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                if (tick) begin
                    if (alarm_cnt_q == ALARM_LAST) begin
                        state_d = IDLE;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + AW'(1);
                    end
                end
                if (start || pause) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
        end
        if (state_d != ALARM) begin
            alarm_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign alarm   = (state_q == ALARM);
    assign running = (state_q == RUN);
    assign state   = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - directed bench with BCD counter models on the cnt_* feedback
module tb_countdown_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] cfg_min = 8'h00;
    logic [7:0] cfg_sec = 8'h00;
    logic [7:0] cnt_min = 8'h00;
    logic [7:0] cnt_sec = 8'h00;
    logic       load;
    logic       sec_dec;
    logic       min_dec;
    logic       alarm;
    logic       running;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    countdown_timer_ctrl #(
        .TICK_DIV   (4),
        .ALARM_SECS (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .cfg_min (cfg_min),
        .cfg_sec (cfg_sec),
        .cnt_min (cnt_min),
        .cnt_sec (cnt_sec),
        .load    (load),
        .sec_dec (sec_dec),
        .min_dec (min_dec),
        .alarm   (alarm),
        .running (running),
        .state   (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)        return 8'h59;
        if (v[3:0] == 4'h0)    return {v[7:4] - 4'd1, 4'h9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always @(posedge clk) begin
        if (load) begin
            cnt_min <= cfg_min;
            cnt_sec <= cfg_sec;
        end else begin
            if (sec_dec) cnt_sec <= bcd_dec(cnt_sec);
            if (min_dec) cnt_min <= bcd_dec(cnt_min);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] m, input logic [7:0] s);
        cfg_min = m;
        cfg_sec = s;
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        // reset state
        cyc(2);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_load", 16'(load), 16'd1);
        chk("rst_sec_dec", 16'(sec_dec), 16'd0);
        chk("rst_min_dec", 16'(min_dec), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        chk("rst_running", 16'(running), 16'd0);
        reset = 1'b1;
        cyc();

        // 1: 01:00 borrows into minutes on the first tick
        set_cfg(8'h01, 8'h00);
        start = 1'b1;
        chk("t1_load_c0", 16'(load), 16'd1);
        cyc();
        start = 1'b0;
        chk("t1_load_c1", 16'(load), 16'd0);
        chk("t1_running", 16'(running), 16'd1);
        chk("t1_state", 16'(state), 16'd1);
        cyc(2);
        chk("t1_sec_dec_c3", 16'(sec_dec), 16'd0);
        cyc();
        chk("t1_sec_dec_c4", 16'(sec_dec), 16'd1);
        chk("t1_min_dec_c4", 16'(min_dec), 16'd1);
        cyc();
        chk("t1_cnt_c5", {cnt_min, cnt_sec}, 16'h0059);
        chk("t1_sec_dec_c5", 16'(sec_dec), 16'd0);
        cyc(3);
        chk("t1_sec_dec_c8", 16'(sec_dec), 16'd1);
        chk("t1_min_dec_c8", 16'(min_dec), 16'd0);
        cyc();
        chk("t1_cnt_c9", {cnt_min, cnt_sec}, 16'h0058);
        do_clear();
        chk("t1_clear_state", 16'(state), 16'd0);

        // 2: 00:02 runs into an unacknowledged alarm
        set_cfg(8'h00, 8'h02);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(3);
        chk("t2_sec_dec_c4", 16'(sec_dec), 16'd1);
        cyc();
        chk("t2_cnt_c5", {cnt_min, cnt_sec}, 16'h0001);
        cyc(3);
        chk("t2_sec_dec_c8", 16'(sec_dec), 16'd1);
        chk("t2_state_c8", 16'(state), 16'd1);
        cyc();
        chk("t2_cnt_c9", {cnt_min, cnt_sec}, 16'h0000);
        chk("t2_state_c9", 16'(state), 16'd3);
        chk("t2_alarm_c9", 16'(alarm), 16'd1);
        cyc(7);
        chk("t2_alarm_c16", 16'(alarm), 16'd1);
        cyc();
        chk("t2_state_c17", 16'(state), 16'd0);
        chk("t2_load_c17", 16'(load), 16'd1);
        chk("t2_alarm_c17", 16'(alarm), 16'd0);

        // 3: pause keeps the sub-second phase
        set_cfg(8'h00, 8'h05);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk("t3_state_pause", 16'(state), 16'd2);
        for (int i = 0; i < 20; i++) begin
            chk("t3_no_strobe", 16'({sec_dec, min_dec}), 16'd0);
            cyc();
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t3_resume_state", 16'(state), 16'd1);
        chk("t3_sec_dec_r1", 16'(sec_dec), 16'd0);
        cyc();
        chk("t3_sec_dec_r2", 16'(sec_dec), 16'd1);
        cyc();
        chk("t3_cnt", {cnt_min, cnt_sec}, 16'h0004);
        do_clear();

        // 4: zero preset ignores start
        set_cfg(8'h00, 8'h00);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_state", 16'(state), 16'd0);
        chk("t4_load", 16'(load), 16'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_no_strobe", 16'({sec_dec, min_dec}), 16'd0);
            cyc();
        end

        // 5: tick and pause together, then clear beats start
        set_cfg(8'h00, 8'h30);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(3);
        pause = 1'b1;
        chk("t5_sec_dec", 16'(sec_dec), 16'd1);
        cyc();
        pause = 1'b0;
        chk("t5_cnt", {cnt_min, cnt_sec}, 16'h0029);
        chk("t5_state", 16'(state), 16'd2);
        clear = 1'b1;
        start = 1'b1;
        cyc();
        clear = 1'b0;
        start = 1'b0;
        chk("t5_clr_state", 16'(state), 16'd0);
        chk("t5_clr_load", 16'(load), 16'd1);

        // 6a: acknowledge alarm on its first cycle
        set_cfg(8'h00, 8'h01);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(4);
        chk("t6_alarm_first", 16'(alarm), 16'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_ack_state", 16'(state), 16'd0);
        chk("t6_ack_alarm", 16'(alarm), 16'd0);

        // 6b: asynchronous reset while a strobe is active
        set_cfg(8'h00, 8'h10);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(3);
        chk("t6_pre_sec_dec", 16'(sec_dec), 16'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_rst_state", 16'(state), 16'd0);
        chk("t6_rst_load", 16'(load), 16'd1);
        chk("t6_rst_sec_dec", 16'(sec_dec), 16'd0);
        chk("t6_rst_running", 16'(running), 16'd0);
        chk("t6_rst_alarm", 16'(alarm), 16'd0);
        #2;
        reset = 1'b1;
        cyc();
        chk("t6_post_load", 16'(load), 16'd1);
        chk("t6_post_state", 16'(state), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
